// File: rtl/cla_pipe_addsub_pkg.sv
// cla_pkg: shared constants and stage-count helper for the pipelined CLA adder/subtractor.
package cla_pkg;

    localparam int DEFAULT_GROUP = 4;

    function automatic int stages(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if: operand/result valid-ready bus of the pipelined CLA adder/subtractor.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );

endinterface

// File: rtl/cla_pipe_addsub_group.sv
// cla_group: one GROUP-bit combinational carry-lookahead slice.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP:0]   w_c;
    logic             w_t;
    logic             w_pp;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is a flat sum of generate terms gated by the propagates above them.
    always_comb begin
        w_c  = '0;
        w_t  = 1'b0;
        w_pp = 1'b1;
        for (int i = 0; i <= GROUP; i++) begin
            w_pp = 1'b1;
            w_t  = 1'b0;
            for (int j = i - 1; j >= 0; j--) begin
                w_t  = w_t | (w_g[j] & w_pp);
                w_pp = w_pp & w_p[j];
            end
            w_c[i] = w_t | (w_pp & ci);
        end
    end

    assign s  = w_p ^ w_c[GROUP-1:0];
    assign co = w_c[GROUP];
    assign cm = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined CLA add/subtract, one lookahead group resolved per stage,
// with valid/ready backpressure that freezes the whole pipeline.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_addsub_if.slave bus
);

    localparam int N = stages(WIDTH, GROUP);

    if (WIDTH % GROUP != 0 || WIDTH < GROUP) begin : g_chk
        $fatal(1, "cla_pipe_addsub: WIDTH must be a positive multiple of GROUP");
    end

    logic w_en;

    assign w_en         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    for (genvar k = 0; k < N; k++) begin : g_st
        // Operands shrink and results grow by one group per stage, so no register bit idles.
        localparam int OW = WIDTH - k * GROUP;
        localparam int RW = (k + 1) * GROUP;

        logic [OW-1:0]    w_a;
        logic [OW-1:0]    w_b;
        logic             w_c;
        logic             w_v;
        logic [GROUP-1:0] w_gs;
        logic             w_co;
        logic             w_cm;
        logic [RW-1:0]    w_sn;
        logic [RW-1:0]    r_s;
        logic             r_c;
        logic             r_v;

        if (k == 0) begin : g_in
            assign w_a  = bus.a;
            assign w_b  = bus.sub ? ~bus.b : bus.b;
            assign w_c  = bus.cin ^ bus.sub;
            assign w_v  = bus.in_valid;
            assign w_sn = w_gs;
        end else begin : g_lnk
            assign w_a  = g_st[k-1].g_op.r_a;
            assign w_b  = g_st[k-1].g_op.r_b;
            assign w_c  = g_st[k-1].r_c;
            assign w_v  = g_st[k-1].r_v;
            assign w_sn = {w_gs, g_st[k-1].r_s};
        end

        cla_group #(.GROUP(GROUP)) u_grp (
            .a  (w_a[GROUP-1:0]),
            .b  (w_b[GROUP-1:0]),
            .ci (w_c),
            .s  (w_gs),
            .co (w_co),
            .cm (w_cm)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v;
                r_c <= w_co;
                r_s <= w_sn;
            end
        end

        if (k < N - 1) begin : g_op
            logic [OW-GROUP-1:0] r_a;
            logic [OW-GROUP-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[OW-1:GROUP];
                    r_b <= w_b[OW-1:GROUP];
                end
            end
        end else begin : g_out
            logic r_o;
            logic r_z;

            // zero is registered rather than decoded from s so it reads 0 out of reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_o <= 1'b0;
                    r_z <= 1'b0;
                end else if (w_en) begin
                    r_o <= w_co ^ w_cm;
                    r_z <= w_sn == '0;
                end
            end
        end
    end

    assign bus.out_valid = g_st[N-1].r_v;
    assign bus.s         = g_st[N-1].r_s;
    assign bus.cout      = g_st[N-1].r_c;
    assign bus.ovf       = g_st[N-1].g_out.r_o;
    assign bus.zero      = g_st[N-1].g_out.r_z;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: randomized and directed checks of cla_pipe_addsub against an arithmetic model.
module tb_cla_pipe_addsub;

    localparam int W = 16;
    localparam int G = 4;
    localparam int L = W / G;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(W)) bus ();

    cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
        int           cyc;
        int           st;
    } beat_t;

    beat_t q[$];
    int    n_chk   = 0;
    int    n_pass  = 0;
    int    cyc     = 0;
    int    n_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci, input logic sb);
        beat_t r;
        int    sa, sv, c, res, ua;
        sa = $signed(a);
        sv = $signed(b);
        c  = int'(ci);
        if (!sb) begin
            ua   = int'(a) + int'(b) + c;
            res  = sa + sv + c;
            r.co = ua >= (1 << W);
            r.s  = W'(ua);
        end else begin
            res  = sa - sv - c;
            r.co = int'(a) >= int'(b) + c;
            r.s  = W'(int'(a) - int'(b) - c);
        end
        r.ov  = res > 32767 || res < -32768;
        r.z   = r.s == '0;
        r.cyc = 0;
        r.st  = 0;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                n_stall++;
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_head_present", q.size() > 0, 1);
                if (q.size() > 0) check("stall_s_stable", bus.s, q[0].s);
            end else begin
                check("in_ready", bus.in_ready, 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("phantom_beat_queue_depth", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("s", bus.s, e.s);
                    check("cout", bus.cout, e.co);
                    check("ovf", bus.ovf, e.ov);
                    check("zero", bus.zero, e.z);
                    check("latency", cyc - e.cyc, L + n_stall - e.st);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e     = model(bus.a, bus.b, bus.cin, bus.sub);
                e.cyc = cyc;
                e.st  = n_stall;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
        int   n;
        logic acc;
        n            = 0;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.sub      = sb;
        do begin
            @(negedge clk);
            acc = bus.in_ready && !rst;
            step();
            n++;
        end while (!acc && n < 100);
        check("accepted", acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) step();
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_s", bus.s, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_in_ready", bus.in_ready, 1);
        step();

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        drain();

        fork
            begin
                repeat (8) step();
                bus.out_ready = 1'b0;
                repeat (3) step();
                bus.out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 20; i++) send_rand();
        drain();

        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_s", bus.s, 0);
        check("flush_zero", bus.zero, 0);
        step();
        repeat (6) step();
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 10; i++) begin
            send_rand();
            step();
        end
        drain();

        repeat (6) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
